// File: rtl/idma_be_req_arbiter_pkg.sv
// Shared constants and helpers for the iDMA backend request arbiter.
package idma_be_req_arbiter_pkg;

  localparam int unsigned MaxNumReq = 8;
  localparam int unsigned CntWidth  = 32;

  function automatic int unsigned idx_width(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/idma_be_req_arbiter_id_fifo.sv
// In-order FIFO recording which requester owns each backend request in flight.
module idma_be_req_arbiter_id_fifo
  import idma_be_req_arbiter_pkg::*;
#(
  parameter int unsigned Depth     = 4,
  parameter int unsigned DataWidth = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 pop_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [DataWidth-1:0] mem [Depth];
  logic [PtrW-1:0]      wr_ptr;
  logic [PtrW-1:0]      rd_ptr;
  logic [CntW-1:0]      cnt;
  logic                 push_ok;
  logic                 pop_ok;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt == CntW'(Depth));
  assign empty_o = (cnt == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign data_o  = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CntW'(1);
        2'b01:   cnt <= cnt - CntW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/idma_be_req_arbiter.sv
// Round-robin arbiter sharing one iDMA backend between NumReq frontends, with in-order response routing.
// Optional per-requester grant counters: define IDMA_BE_REQ_ARBITER_STATS_EN.
module idma_be_req_arbiter
  import idma_be_req_arbiter_pkg::*;
#(
  parameter int unsigned NumReq       = 2,
  parameter int unsigned RspFifoDepth = 4,
  parameter type         idma_req_t   = logic,
  parameter type         idma_rsp_t   = logic
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  idma_req_t [NumReq-1:0]           req_i,
  input  logic      [NumReq-1:0]           req_valid_i,
  output logic      [NumReq-1:0]           req_ready_o,
  output idma_rsp_t [NumReq-1:0]           rsp_o,
  output logic      [NumReq-1:0]           rsp_valid_o,
  input  logic      [NumReq-1:0]           rsp_ready_i,
  output idma_req_t                        be_req_o,
  output logic                             be_req_valid_o,
  input  logic                             be_req_ready_i,
  input  idma_rsp_t                        be_rsp_i,
  input  logic                             be_rsp_valid_i,
  output logic                             be_rsp_ready_o,
  output logic                             busy_o,
  output logic                             err_o,
  output logic [NumReq-1:0][CntWidth-1:0]  grant_cnt_o
);

  localparam int unsigned IdxW = idx_width(NumReq);

  logic [IdxW-1:0] last_idx;
  logic [IdxW-1:0] lock_idx;
  logic            lock_vld;
  logic [IdxW-1:0] cand_hi_idx;
  logic [IdxW-1:0] cand_lo_idx;
  logic            cand_hi_vld;
  logic            cand_lo_vld;
  logic [IdxW-1:0] gnt_idx;
  logic            gnt_vld;
  logic [IdxW-1:0] head_idx;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;

  // Candidate search: lowest valid index above last_idx, else lowest valid overall (wrap).
  always_comb begin
    cand_hi_vld = 1'b0;
    cand_hi_idx = '0;
    cand_lo_vld = 1'b0;
    cand_lo_idx = '0;
    for (int i = int'(NumReq) - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        cand_lo_vld = 1'b1;
        cand_lo_idx = IdxW'(i);
        if (IdxW'(i) > last_idx) begin
          cand_hi_vld = 1'b1;
          cand_hi_idx = IdxW'(i);
        end
      end
    end
  end

  // A stalled grant stays on its requester until the backend accepts it.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (lock_vld && req_valid_i[lock_idx]) begin
      gnt_vld = 1'b1;
      gnt_idx = lock_idx;
    end else if (cand_hi_vld) begin
      gnt_vld = 1'b1;
      gnt_idx = cand_hi_idx;
    end else begin
      gnt_vld = cand_lo_vld;
      gnt_idx = cand_lo_idx;
    end
  end

  assign be_req_valid_o = !rst_i && gnt_vld && !fifo_full;
  assign be_req_o       = (!rst_i && gnt_vld) ? req_i[gnt_idx] : '0;
  assign push           = be_req_valid_o && be_req_ready_i;
  assign be_rsp_ready_o = !rst_i && !fifo_empty && rsp_ready_i[head_idx];
  assign pop            = be_rsp_valid_i && be_rsp_ready_o;
  assign busy_o         = !rst_i && (!fifo_empty || be_req_valid_o);

  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    rsp_o       = '0;
    for (int i = 0; i < int'(NumReq); i++) begin
      req_ready_o[i] = be_req_valid_o && be_req_ready_i && (gnt_idx == IdxW'(i));
      if (!rst_i && !fifo_empty && (head_idx == IdxW'(i))) begin
        rsp_valid_o[i] = be_rsp_valid_i;
        rsp_o[i]       = be_rsp_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_idx <= IdxW'(NumReq - 1);
      lock_vld <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      if (push) last_idx <= gnt_idx;
      lock_vld <= be_req_valid_o && !be_req_ready_i;
      if (be_rsp_valid_i && fifo_empty) err_o <= 1'b1;
    end
  end

  // Only meaningful while lock_vld is set, so it carries no reset.
  always_ff @(posedge clk_i) begin
    lock_idx <= gnt_idx;
  end

  idma_be_req_arbiter_id_fifo #(
    .Depth     (RspFifoDepth),
    .DataWidth (IdxW)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (gnt_idx),
    .pop_i   (pop),
    .data_o  (head_idx),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef IDMA_BE_REQ_ARBITER_STATS_EN
  logic [NumReq-1:0][CntWidth-1:0] grant_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      grant_cnt <= '0;
    end else if (push) begin
      grant_cnt[gnt_idx] <= grant_cnt[gnt_idx] + CntWidth'(1);
    end
  end

  assign grant_cnt_o = grant_cnt;
`else
  assign grant_cnt_o = '0;
`endif

endmodule

// File: doc/idma_be_req_arbiter.md
IDMA_BE_REQ_ARBITER -- requirements
Module: idma_be_req_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 2: number of requesters (frontends) sharing one iDMA backend; legal range 2..8.
REQ-002 SHALL have parameter RspFifoDepth, default 4: number of backend requests in flight whose origin is tracked; legal range 2..16.
REQ-003 SHALL have type parameters idma_req_t and idma_rsp_t, both default logic: the full iDMA request and response structs.
REQ-004 SHALL have ports (name, direction, width, meaning):
- clk_i  in  1  sole clock.
- rst_i  in  1  reset, synchronous, active-high.
- req_i  in  NumReq x idma_req_t  per-requester transfer request.
- req_valid_i  in  NumReq  per-requester request valid.
- req_ready_o  out  NumReq  per-requester request ready.
- rsp_o  out  NumReq x idma_rsp_t  per-requester response.
- rsp_valid_o  out  NumReq  per-requester response valid.
- rsp_ready_i  in  NumReq  per-requester response ready.
- be_req_o  out  idma_req_t  request to the backend.
- be_req_valid_o  out  1  backend request valid.
- be_req_ready_i  in  1  backend request ready.
- be_rsp_i  in  idma_rsp_t  backend response.
- be_rsp_valid_i  in  1  backend response valid.
- be_rsp_ready_o  out  1  backend response ready.
- busy_o  out  1  high while any tracked request is outstanding.
- err_o  out  1  sticky: backend response arrived with nothing outstanding.
- grant_cnt_o  out  NumReq x 32  per-requester accepted-request counters.

Function
REQ-005 SHALL arbitrate round-robin: the candidate is the lowest valid index strictly above the last granted index, wrapping to 0; after reset, the last granted index is NumReq-1.
REQ-006 SHALL forward the candidate's req_i to be_req_o combinationally, with 0-cycle latency, and SHALL assert req_ready_o only for the granted index, equal to be_req_ready_i.
REQ-007 SHALL lock the grant while be_req_valid_o=1 and be_req_ready_i=0; be_req_o and the granted index SHALL stay stable until the handshake, even if a higher-priority requester becomes valid.
REQ-008 SHALL update the last granted index only on a backend request handshake.
REQ-009 SHALL push the granted index into an in-order ID FIFO on each backend request handshake.
REQ-010 SHALL force be_req_valid_o=0 and all req_ready_o=0 while the ID FIFO is full, even if a response pops in the same cycle; a push never coincides with a full FIFO.
REQ-011 SHALL route a backend response to the index at the FIFO head: rsp_o[head]=be_rsp_i, rsp_valid_o[head]=be_rsp_valid_i, be_rsp_ready_o=rsp_ready_i[head]; all other rsp_valid_o SHALL be 0.
REQ-012 SHALL pop the FIFO on a backend response handshake; a push and a pop in the same cycle SHALL leave the occupancy unchanged.
REQ-013 SHALL hold be_rsp_ready_o=0 when the FIFO is empty; be_rsp_valid_i=1 with an empty FIFO SHALL set err_o on the next edge, and err_o SHALL stay set until reset.
REQ-014 SHALL drive busy_o = (FIFO not empty) OR be_req_valid_o.
REQ-015 SHALL drive rsp_o[i] to zero for every non-head index.

Reset
REQ-016 SHALL, on rst_i sampled high, empty the FIFO, set the last granted index to NumReq-1, and clear err_o and all grant_cnt_o.
REQ-017 SHALL, in the cycle rst_i is high, drive all valid and ready outputs to 0, busy_o=0, and be_req_o=0.
REQ-018 SHALL discard in-flight tracking when reset is asserted mid-operation; responses that arrive after reset SHALL fall under REQ-013.

Configuration
REQ-019 SHALL, when IDMA_BE_REQ_ARBITER_STATS_EN is defined, increment grant_cnt_o[i] by 1 on each handshake granted to requester i, wrapping modulo 2^32.
REQ-020 SHALL, when IDMA_BE_REQ_ARBITER_STATS_EN is undefined, tie grant_cnt_o to 0 and instantiate no counter flops; the port SHALL remain present.

Structure
REQ-021 SHALL place MaxNumReq=8, CntWidth=32, and the function computing index width from NumReq in package idma_be_req_arbiter_pkg.
REQ-022 SHALL implement the ID FIFO as sub-module idma_be_req_arbiter_id_fifo, parameterised by depth and data width, with a synchronous active-high reset and full/empty flags.

Verification
REQ-023 SHALL cover this case: NumReq=2, both valid continuously, be_req_ready_i=1 -> grants alternate 0,1,0,1, and each grant_cnt_o reads 2 after 4 cycles (STATS_EN defined).
REQ-024 SHALL cover this case: requester 1 is granted with be_req_ready_i held low for 3 cycles while requester 0 asserts valid -> be_req_o stays equal to req_i[1] for those 3 cycles.
REQ-025 SHALL cover this case: RspFifoDepth=4, 4 requests accepted with no responses -> be_req_valid_o=0 on the 5th request until one response pops, after which that request is granted.
REQ-026 SHALL cover this case: requests issued in order 1,0,1 and three backend responses returned -> responses appear on rsp_valid_o indices 1, 0, 1 in that order, and busy_o falls after the third.
REQ-027 SHALL cover this case: be_rsp_valid_i=1 with an empty FIFO -> be_rsp_ready_o=0 and err_o=1 from the next cycle, held until rst_i pulses.
REQ-028 SHALL cover this case: rst_i asserted with 2 requests outstanding -> busy_o=0 on the next cycle, and the next grant goes to index 0.
